stk_arbiter: RTL and testbench

- Owns the AZ10 data stack (LIFO storage plus stack pointer).
- Shares the stack between NREQ requesters: PC branch-target pop, ALU operand push/pop, and program loader push.
- Round-robin arbitration. One push or pop is serviced per transaction, with a fixed 3-cycle sequence.
- Replaces direct stk_pop/stk_data_out wiring between the PC and the stack.

---
 rtl/az10_pkg.sv | 16 +
 rtl/stk_arbiter_if.sv | 44 ++++
 rtl/rr_picker.sv | 25 ++
 rtl/stk_arbiter.sv | 124 ++++++++++++
 tb/tb_stk_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/az10_pkg.sv
// Shared AZ10 definitions: stack defaults, op encodings and the stack arbiter FSM states.
package az10_pkg;

  localparam int DATA_LEN_DEF  = 8;
  localparam int STK_DEPTH_DEF = 16;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stk_state_t;

endpackage

// File: rtl/stk_arbiter_if.sv
// Requester-side bus of the AZ10 data stack arbiter; clr exists only when STK_CLEAR_EN is defined.
interface stk_arbiter_if
  import az10_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
);

  localparam int SPW = $clog2(STK_DEPTH) + 1;

  // Handshake: a requester raises req with op/wdata stable and holds all three
  // until its single-cycle gnt pulse; rdata and err are meaningful only with gnt.
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          op;
  logic [NREQ*DATA_LEN-1:0] wdata;
`ifdef STK_CLEAR_EN
  logic                     clr;
`endif
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          err;
  logic [DATA_LEN-1:0]      rdata;
  logic                     stk_full;
  logic                     stk_empty;
  logic [SPW-1:0]           sp;
  stk_state_t               state;

  modport master (
`ifdef STK_CLEAR_EN
    output clr,
`endif
    output req, op, wdata,
    input  gnt, err, rdata, stk_full, stk_empty, sp, state
  );

  modport slave (
`ifdef STK_CLEAR_EN
    input  clr,
`endif
    input  req, op, wdata,
    output gnt, err, rdata, stk_full, stk_empty, sp, state
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first active request after index last, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  int idx;

  // Scan from farthest to nearest so the nearest active request overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/stk_arbiter.sv
// AZ10 data stack with round-robin shared access; one push/pop per IDLE-ACCESS-RESP transaction.
// Optional STK_CLEAR_EN adds a synchronous clr that empties the stack and aborts any transaction.
module stk_arbiter
  import az10_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int NREQ      = 3
) (
  input  logic          clk,
  input  logic          rst,
  stk_arbiter_if.slave  bus
);

  localparam int AW  = $clog2(STK_DEPTH);
  localparam int SPW = AW + 1;
  localparam int IW  = $clog2(NREQ);

  stk_state_t          state_q, state_d;
  logic [IW-1:0]       last, win, pick;
  logic                pick_valid;
  logic                op_l;
  logic [DATA_LEN-1:0] wdata_l, rdata_q;
  logic [SPW-1:0]      sp_q, sp_dec;
  logic [NREQ-1:0]     gnt_q, err_q, win_oh;
  logic                full, empty, clr_s;
  logic [DATA_LEN-1:0] mem [STK_DEPTH];

`ifdef STK_CLEAR_EN
  assign clr_s = bus.clr;
`else
  assign clr_s = 1'b0;
`endif

  assign full   = (sp_q == SPW'(STK_DEPTH));
  assign empty  = (sp_q == '0);
  assign sp_dec = sp_q - SPW'(1);
  assign win_oh = NREQ'(1) << win;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (bus.req),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_s) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // gnt/err are written in ACCESS so they are visible for exactly the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= IW'(NREQ - 1);
      win     <= '0;
      op_l    <= OP_POP;
      wdata_l <= '0;
      sp_q    <= '0;
      gnt_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else if (clr_s) begin
      sp_q  <= '0;
      gnt_q <= '0;
      err_q <= '0;
    end else begin
      gnt_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win     <= pick;
            op_l    <= bus.op[pick];
            wdata_l <= bus.wdata[int'(pick)*DATA_LEN +: DATA_LEN];
          end
        end
        ACCESS: begin
          last  <= win;
          gnt_q <= win_oh;
          if (op_l == OP_PUSH) begin
            if (full) err_q <= win_oh;
            else      sp_q  <= sp_q + SPW'(1);
          end else begin
            if (empty) begin
              rdata_q <= '0;
              err_q   <= win_oh;
            end else begin
              rdata_q <= mem[sp_dec[AW-1:0]];
              sp_q    <= sp_dec;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left unreset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && op_l == OP_PUSH && !full && !clr_s)
      mem[sp_q[AW-1:0]] <= wdata_l;
  end

  assign bus.gnt       = gnt_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.sp        = sp_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_stk_arbiter.sv
// Directed self-checking bench for stk_arbiter (default 8-bit x 16 entries, 3 requesters).
module tb_stk_arbiter;
  import az10_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stk_arbiter_if #(.NREQ(3), .DATA_LEN(8), .STK_DEPTH(16)) bus ();

  stk_arbiter #(.DATA_LEN(8), .STK_DEPTH(16), .NREQ(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
`ifdef STK_CLEAR_EN
    bus.clr   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one request and waits (bounded) for its gnt; lat = -1 on timeout.
  task automatic do_op(input int i, input logic o, input logic [7:0] d,
                       output int lat, output logic [2:0] g, output logic [2:0] e,
                       output logic [7:0] rd, output logic [4:0] s);
    bus.req[i]            = 1'b1;
    bus.op[i]             = o;
    bus.wdata[i*8 +: 8]   = d;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.gnt !== 3'b000) begin
        lat = c;
        break;
      end
    end
    g  = bus.gnt;
    e  = bus.err;
    rd = bus.rdata;
    s  = bus.sp;
    bus.req[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.wdata = '0;
`ifdef STK_CLEAR_EN
    bus.clr = 1'b0;
`endif
    #1;
    checks++;
    if (bus.gnt !== 3'b000 || bus.err !== 3'b000 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b err=%b rdata=%h, required 000 000 00",
               bus.gnt, bus.err, bus.rdata);
    end
    checks++;
    if (bus.sp !== 5'd0 || bus.stk_empty !== 1'b1 || bus.stk_full !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset_stack: sp=%0d empty=%b full=%b state=%0d, required 0 1 0 0",
               bus.sp, bus.stk_empty, bus.stk_full, bus.state);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s; logic em;
    apply_reset();
    do_op(0, OP_PUSH, 8'hA5, lat, g, e, rd, s);
    checks++;
    if (lat !== 2 || g !== 3'b001 || e !== 3'b000 || s !== 5'd1) begin
      errors++;
      $display("FAIL single_push: lat=%0d gnt=%b err=%b sp=%0d, required 2 001 000 1", lat, g, e, s);
    end
    checks++;
    if (bus.stk_empty !== 1'b0 || bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL single_push_flags: empty=%b gnt=%b, required 0 000", bus.stk_empty, bus.gnt);
    end
    do_op(0, OP_POP, 8'h00, lat, g, e, rd, s);
    em = bus.stk_empty;
    checks++;
    if (lat !== 2 || g !== 3'b001 || e !== 3'b000 || rd !== 8'hA5 || s !== 5'd0 || em !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: lat=%0d gnt=%b err=%b rdata=%h sp=%0d empty=%b, required 2 001 000 a5 0 1",
               lat, g, e, rd, s, em);
    end
  endtask

  task automatic test_fairness();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s;
    logic [2:0]  exp_g [4];
    logic [7:0]  exp_pop [4];
    logic [2:0]  got;
    int          waited;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_pop[0] = 8'h11; exp_pop[1] = 8'h30; exp_pop[2] = 8'h20; exp_pop[3] = 8'h10;
    apply_reset();
    bus.op    = 3'b111;
    bus.wdata = {8'h30, 8'h20, 8'h10};
    bus.req   = 3'b111;
    for (int n = 0; n < 4; n++) begin
      got = 3'b000;
      waited = 0;
      while (got === 3'b000 && waited < 8) begin
        @(negedge clk);
        waited++;
        got = bus.gnt;
      end
      checks++;
      if (got !== exp_g[n]) begin
        errors++;
        $display("FAIL fair_order%0d: gnt=%b, required %b", n, got, exp_g[n]);
      end
      if (n == 0) bus.wdata[7:0] = 8'h11;
      if (n == 3) bus.req = 3'b000;
    end
    @(negedge clk);
    checks++;
    if (bus.sp !== 5'd4) begin
      errors++;
      $display("FAIL fair_sp: sp=%0d, required 4", bus.sp);
    end
    for (int n = 0; n < 4; n++) begin
      do_op(0, OP_POP, 8'h00, lat, g, e, rd, s);
      checks++;
      if (g !== 3'b001 || rd !== exp_pop[n]) begin
        errors++;
        $display("FAIL fair_pop%0d: gnt=%b rdata=%h, required 001 %h", n, g, rd, exp_pop[n]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s;
    apply_reset();
    for (int n = 0; n < 16; n++) do_op(1, OP_PUSH, 8'h40 + 8'(n), lat, g, e, rd, s);
    checks++;
    if (bus.sp !== 5'd16 || bus.stk_full !== 1'b1 || bus.stk_empty !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill: sp=%0d full=%b empty=%b, required 16 1 0",
               bus.sp, bus.stk_full, bus.stk_empty);
    end
    do_op(1, OP_PUSH, 8'hEE, lat, g, e, rd, s);
    checks++;
    if (g !== 3'b010 || e !== 3'b010 || s !== 5'd16) begin
      errors++;
      $display("FAIL ovf_push: gnt=%b err=%b sp=%0d, required 010 010 16", g, e, s);
    end
    do_op(1, OP_POP, 8'h00, lat, g, e, rd, s);
    checks++;
    if (g !== 3'b010 || e !== 3'b000 || rd !== 8'h4F || s !== 5'd15 || bus.stk_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pop: gnt=%b err=%b rdata=%h sp=%0d full=%b, required 010 000 4f 15 0",
               g, e, rd, s, bus.stk_full);
    end
  endtask

  task automatic test_underflow();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s;
    apply_reset();
    do_op(2, OP_PUSH, 8'h77, lat, g, e, rd, s);
    do_op(2, OP_POP, 8'h00, lat, g, e, rd, s);
    checks++;
    if (rd !== 8'h77 || e !== 3'b000) begin
      errors++;
      $display("FAIL unf_prep: rdata=%h err=%b, required 77 000", rd, e);
    end
    do_op(2, OP_POP, 8'h00, lat, g, e, rd, s);
    checks++;
    if (g !== 3'b100 || e !== 3'b100 || rd !== 8'h00 || s !== 5'd0) begin
      errors++;
      $display("FAIL unf_pop: gnt=%b err=%b rdata=%h sp=%0d, required 100 100 00 0", g, e, rd, s);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s;
    logic [2:0] got;
    int waited;
    apply_reset();
    do_op(0, OP_PUSH, 8'h55, lat, g, e, rd, s);
    bus.req[1] = 1'b1; bus.op[1] = OP_PUSH; bus.wdata[15:8] = 8'h66;
    @(negedge clk);
    checks++;
    if (bus.state !== ACCESS) begin
      errors++;
      $display("FAIL midrst_access: state=%0d, required %0d", bus.state, ACCESS);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.req = 3'b000;
    rst = 1'b0;
    checks++;
    if (bus.gnt !== 3'b000 || bus.sp !== 5'd0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL midrst_abort: gnt=%b sp=%0d state=%0d, required 000 0 0",
               bus.gnt, bus.sp, bus.state);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b000) begin
      errors++;
      $display("FAIL midrst_nognt: gnt=%b, required 000", bus.gnt);
    end
    bus.op = 3'b011; bus.wdata = {8'h00, 8'h22, 8'h11};
    bus.req = 3'b011;
    got = 3'b000; waited = 0;
    while (got === 3'b000 && waited < 8) begin
      @(negedge clk);
      waited++;
      got = bus.gnt;
    end
    bus.req = 3'b000;
    checks++;
    if (got !== 3'b001 || bus.sp !== 5'd1) begin
      errors++;
      $display("FAIL midrst_prio: gnt=%b sp=%0d, required 001 1", got, bus.sp);
    end
    @(negedge clk);
  endtask

`ifdef STK_CLEAR_EN
  task automatic test_clear();
    int lat; logic [2:0] g, e; logic [7:0] rd; logic [4:0] s;
    logic [2:0] got;
    int waited;
    apply_reset();
    for (int n = 0; n < 3; n++) do_op(0, OP_PUSH, 8'h90 + 8'(n), lat, g, e, rd, s);
    bus.req[0] = 1'b1; bus.op[0] = OP_PUSH; bus.wdata[7:0] = 8'h99;
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    checks++;
    if (bus.sp !== 5'd0 || bus.gnt !== 3'b000 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL clr_abort: sp=%0d gnt=%b state=%0d, required 0 000 0",
               bus.sp, bus.gnt, bus.state);
    end
    got = 3'b000; waited = 0;
    while (got === 3'b000 && waited < 8) begin
      @(negedge clk);
      waited++;
      got = bus.gnt;
    end
    bus.req = 3'b000;
    checks++;
    if (got !== 3'b001 || bus.sp !== 5'd1) begin
      errors++;
      $display("FAIL clr_regrant: gnt=%b sp=%0d, required 001 1", got, bus.sp);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_underflow();
    test_mid_reset();
`ifdef STK_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
